// File: rtl/div_period_checker.sv
// Divided-clock period checker.
// Measures the cycle distance between consecutive edges of div_in, checks each
// half-period against EXP_HALF +/- TOL, tracks lock and stall, and hands every
// measurement to a consumer over a valid/ready port that holds a single result.
module div_period_checker #(
  parameter int EXP_HALF = 3,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_len,
  output logic             m_level,
  output logic             m_err,
  output logic             locked,
  output logic             stall,
  output logic             ovf,
  output logic [7:0]       err_cnt
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic             div_q,     div_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [RUN_W-1:0] run_q,     run_d;
  logic             m_valid_q, m_valid_d;
  logic [CNT_W-1:0] m_len_q,   m_len_d;
  logic             m_level_q, m_level_d;
  logic             m_err_q,   m_err_d;
  logic             locked_q,  locked_d;
  logic             stall_q,   stall_d;
  logic             ovf_q,     ovf_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic edge_det;
  logic meas_err;
  logic measure;

  // Edge detection is only meaningful once div_q holds a real sample of div_in.
  assign edge_det = ((state_q == ST_ARMED) || (state_q == ST_MEASURE)) && (div_in != div_q);
  assign meas_err = (int'(cnt_q) < EXP_HALF - TOL) || (int'(cnt_q) > EXP_HALF + TOL);

  // Next-state logic: edge FSM, counter, output slot, lock and error tracking.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    div_d     = div_in;
    cnt_d     = cnt_q;
    run_d     = run_q;
    m_valid_d = m_valid_q;
    m_len_d   = m_len_q;
    m_level_d = m_level_q;
    m_err_d   = m_err_q;
    locked_d  = locked_q;
    stall_d   = stall_q;
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;
    measure   = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_ARMED;
      ST_ARMED: begin
        // First edge after reset or stall only starts the count.
        if (edge_det) begin
          cnt_d   = CNT_W'(1);
          stall_d = 1'b0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (edge_det) begin
          measure = 1'b1;
          cnt_d   = CNT_W'(1);
        end else if (int'(cnt_q) >= TIMEOUT) begin
          stall_d  = 1'b1;
          locked_d = 1'b0;
          run_d    = '0;
          state_d  = ST_ARMED;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Consumer took the held result.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (measure) begin
      // Slot is free (or being emptied this cycle): load; otherwise drop and flag.
      if (!m_valid_q || m_ready) begin
        m_valid_d = 1'b1;
        m_len_d   = cnt_q;
        m_level_d = div_q;
        m_err_d   = meas_err;
      end else begin
        ovf_d = 1'b1;
      end

      // Lock/error tracking sees every measurement, dropped or not.
      if (meas_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        run_d    = '0;
        locked_d = 1'b0;
      end else begin
        if (int'(run_q) < LOCK_CNT) run_d = run_q + RUN_W'(1);
        if (int'(run_d) >= LOCK_CNT) locked_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state_q   <= ST_INIT;
      div_q     <= 1'b0;
      cnt_q     <= '0;
      run_q     <= '0;
      m_valid_q <= 1'b0;
      m_len_q   <= '0;
      m_level_q <= 1'b0;
      m_err_q   <= 1'b0;
      locked_q  <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      m_valid_q <= m_valid_d;
      m_len_q   <= m_len_d;
      m_level_q <= m_level_d;
      m_err_q   <= m_err_d;
      locked_q  <= locked_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_len   = m_len_q;
  assign m_level = m_level_q;
  assign m_err   = m_err_q;
  assign locked  = locked_q;
  assign stall   = stall_q;
  assign ovf     = ovf_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_div_period_checker.sv
// Testbench for div_period_checker: directed scenarios plus randomized waves,
// every cycle compared against a timestamp-based reference model.
module tb_div_period_checker;

  localparam int EXP_HALF = 3;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 64;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_in;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_len;
  logic             m_level;
  logic             m_err;
  logic             locked;
  logic             stall;
  logic             ovf;
  logic [7:0]       err_cnt;

  div_period_checker #(
    .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_len   (m_len),
    .m_level (m_level),
    .m_err   (m_err),
    .locked  (locked),
    .stall   (stall),
    .ovf     (ovf),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: edges are timestamps; a half-period is the difference
  // between consecutive edge timestamps; the output is a one-entry slot.
  int   cyc       = 0;
  int   arm_at    = 0;
  int   last_edge = -1;
  logic prev_div  = 1'b0;
  logic e_valid = 1'b0, e_level = 1'b0, e_err = 1'b0;
  logic e_locked = 1'b0, e_stall = 1'b0, e_ovf = 1'b0;
  int   e_len = 0, e_errcnt = 0, run = 0;

  task automatic model(input logic d, input logic rdy, input logic r);
    bit meas;
    bit bad;
    int len;
    meas = 1'b0;
    bad  = 1'b0;
    len  = 0;
    if (r) begin
      e_valid = 0; e_len = 0; e_level = 0; e_err = 0;
      e_locked = 0; e_stall = 0; e_ovf = 0; e_errcnt = 0; run = 0;
      last_edge = -1;
      arm_at = cyc + 2;
    end else begin
      if (cyc >= arm_at) begin
        if (last_edge < 0) begin
          if (d != prev_div) begin
            last_edge = cyc;
            e_stall   = 0;
          end
        end else if (d != prev_div) begin
          len = cyc - last_edge;
          if (len > CNT_MAX) len = CNT_MAX;
          meas = 1'b1;
          last_edge = cyc;
        end else if (cyc - last_edge >= TIMEOUT) begin
          e_stall = 1; e_locked = 0; run = 0; last_edge = -1;
        end
      end
      if (meas) begin
        bad = (len < EXP_HALF - TOL) || (len > EXP_HALF + TOL);
        if (!e_valid || rdy) begin
          e_valid = 1; e_len = len; e_level = prev_div; e_err = bad;
        end else begin
          e_ovf = 1;
        end
        if (bad) begin
          if (e_errcnt < 255) e_errcnt++;
          run = 0;
          e_locked = 0;
        end else begin
          if (run < LOCK_CNT) run++;
          if (run >= LOCK_CNT) e_locked = 1;
        end
      end else if (e_valid && rdy) begin
        e_valid = 0;
      end
    end
    prev_div = r ? 1'b0 : d;
    cyc++;
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic d, input logic rdy, input logic r);
    div_in  = d;
    m_ready = rdy;
    rst     = r;
    model(d, rdy, r);
    @(posedge clk);
    #1;
    check("m_valid", m_valid, e_valid);
    check("m_len",   m_len,   e_len);
    check("m_level", m_level, e_level);
    check("m_err",   m_err,   e_err);
    check("locked",  locked,  e_locked);
    check("stall",   stall,   e_stall);
    check("ovf",     ovf,     e_ovf);
    check("err_cnt", err_cnt, e_errcnt);
  endtask

  logic wv = 1'b0;

  // Flip the wave and hold the new level for per cycles.
  task automatic half(input int per, input logic rdy);
    wv = ~wv;
    for (int i = 0; i < per; i++) step(wv, rdy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  m_valid, 0);
    check({tag, "_len"},    m_len,   0);
    check({tag, "_level"},  m_level, 0);
    check({tag, "_err"},    m_err,   0);
    check({tag, "_locked"}, locked,  0);
    check({tag, "_stall"},  stall,   0);
    check({tag, "_ovf"},    ovf,     0);
    check({tag, "_errcnt"}, err_cnt, 0);
  endtask

  initial begin
    div_in = 1'b0; m_ready = 1'b1; rst = 1'b1;

    // Reset state.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_all_zero("rst");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // Steady toggle every 3 cycles: lock after 4 good measurements.
    for (int i = 0; i < 6; i++) half(3, 1'b1);
    check("s1_locked", locked, 1);
    check("s1_len", m_len, 3);
    check("s1_err", m_err, 0);

    // One half-period stretched to 5 cycles, then relock.
    half(5, 1'b1);
    wv = ~wv;
    step(wv, 1'b1, 1'b0);
    check("s2_valid", m_valid, 1);
    check("s2_len", m_len, 5);
    check("s2_err", m_err, 1);
    check("s2_errcnt", err_cnt, 1);
    check("s2_locked", locked, 0);
    step(wv, 1'b1, 1'b0);
    step(wv, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) half(3, 1'b1);
    check("s2_nolock3", locked, 0);
    half(3, 1'b1);
    check("s2_relock", locked, 1);

    // Back-pressure across two measuring edges: first result held, ovf set.
    half(2, 1'b0);
    half(4, 1'b0);
    wv = ~wv;
    step(wv, 1'b0, 1'b0);
    check("s3_valid", m_valid, 1);
    check("s3_len", m_len, 3);
    check("s3_ovf", ovf, 1);
    check("s3_errcnt", err_cnt, 3);
    step(wv, 1'b1, 1'b0);
    check("s3_accepted", m_valid, 0);
    step(wv, 1'b1, 1'b0);

    // Stall: hold constant well past TIMEOUT.
    for (int i = 0; i < 70; i++) step(wv, 1'b1, 1'b0);
    check("s4_stall", stall, 1);
    check("s4_locked", locked, 0);
    wv = ~wv;
    step(wv, 1'b1, 1'b0);
    check("s4_unstall", stall, 0);
    check("s4_novalid", m_valid, 0);
    step(wv, 1'b1, 1'b0);
    step(wv, 1'b1, 1'b0);
    wv = ~wv;
    step(wv, 1'b0, 1'b0);
    check("s4_valid", m_valid, 1);
    check("s4_len", m_len, 3);

    // Reset while a result is pending.
    step(wv, 1'b0, 1'b0);
    step(wv, 1'b0, 1'b1);
    check_all_zero("s5");
    for (int i = 0; i < 3; i++) step(wv, 1'b0, 1'b0);
    wv = ~wv;
    step(wv, 1'b0, 1'b0);
    check("s5_first_edge", m_valid, 0);

    // Measuring edge coinciding with a handshake.
    step(wv, 1'b0, 1'b0);
    step(wv, 1'b0, 1'b0);
    wv = ~wv;
    step(wv, 1'b0, 1'b0);
    check("s6_loaded", m_len, 3);
    for (int i = 0; i < 3; i++) step(wv, 1'b0, 1'b0);
    wv = ~wv;
    step(wv, 1'b1, 1'b0);
    check("s6_valid", m_valid, 1);
    check("s6_len", m_len, 4);
    check("s6_ovf", ovf, 0);

    // Randomized waves, back-pressure, stalls and resets.
    for (int k = 0; k < 200; k++) begin
      int per;
      per = ($urandom_range(0, 24) == 0) ? 70 : int'($urandom_range(1, 6));
      wv = ~wv;
      for (int j = 0; j < per; j++)
        step(wv, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
